// File: rtl/fifo_rd_stream_adapter.sv
// Read-side FIFO consumer: pops words into a main+skid buffer and presents them as a valid/ready stream.
// Optional transfer counter port wcnt is enabled by defining FIFO_RD_WCNT_EN.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
`ifdef FIFO_RD_WCNT_EN
  output logic [CNT_WIDTH-1:0]  wcnt,
`endif
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            buf_level
);

  typedef enum logic [1:0] {
    LVL0    = 2'd0,
    LVL1    = 2'd1,
    LVL2    = 2'd2,
    LVL_BAD = 2'd3
  } level_t;

  level_t                  state_reg;
  logic [DATA_WIDTH-1:0]   main_reg;
  logic [DATA_WIDTH-1:0]   skid_reg;
  logic                    consume;

  // Pop decision looks only at the registered level, so out_ready never reaches rd_en.
  assign rd_en     = !fifo_empty && (state_reg != LVL2) && !rd_rst;
  assign out_valid = (state_reg != LVL0);
  assign out_data  = main_reg;
  assign buf_level = state_reg;
  assign consume   = out_valid && out_ready;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_reg <= LVL0;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      case (state_reg)
        LVL0: begin
          if (rd_en) begin
            main_reg  <= rd_data;
            state_reg <= LVL1;
          end
        end
        LVL1: begin
          if (rd_en && consume) begin
            main_reg <= rd_data;
          end else if (rd_en) begin
            skid_reg  <= rd_data;
            state_reg <= LVL2;
          end else if (consume) begin
            state_reg <= LVL0;
          end
        end
        LVL2: begin
          if (consume) begin
            main_reg  <= skid_reg;
            state_reg <= LVL1;
          end
        end
        default: state_reg <= LVL0;
      endcase
    end
  end

`ifdef FIFO_RD_WCNT_EN
  logic [CNT_WIDTH-1:0] wcnt_reg;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      wcnt_reg <= '0;
    end else if (consume) begin
      wcnt_reg <= wcnt_reg + 1'b1;
    end
  end

  assign wcnt = wcnt_reg;
`else
  // Counter width only matters when the counter exists; keep it referenced.
  if (CNT_WIDTH < 1) begin : g_cnt_width_unused
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: vector table, streaming, stall, random traffic, async reset.
module tb_fifo_rd_stream_adapter;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          fifo_empty;
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    buf_level;
`ifdef FIFO_RD_WCNT_EN
  logic [CW-1:0] wcnt;
`endif

  int errors = 0;
  int checks = 0;

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .fifo_empty (fifo_empty),
    .rd_data    (rd_data),
    .rd_en      (rd_en),
`ifdef FIFO_RD_WCNT_EN
    .wcnt       (wcnt),
`endif
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .buf_level  (buf_level)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          fe;
    logic [DW-1:0] data;
    logic          rdy;
    logic          exp_rd_en;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_level;
  } vec_t;

  // Software FIFO feeding the DUT, and the expected output order.
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int            got;

  // One cycle: drive at negedge, sample 1ns later, pop the model FIFO at posedge.
  task automatic cycle(input bit rdy, input bit allow);
    bit pop;
    @(negedge rd_clk);
    out_ready  = rdy;
    fifo_empty = !(allow && src_q.size() > 0);
    rd_data    = (src_q.size() > 0) ? src_q[0] : '0;
    #1;
    pop = rd_en;
    if (rd_en && buf_level == 2'd2) check("pop_at_level2", 1, 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("extra_word", 1, 0);
      else check("stream_order", out_data, exp_q.pop_front());
      got++;
    end
    @(posedge rd_clk);
    if (pop) void'(src_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_rst = 1'b1;
    #2;
    rd_rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    got = 0;
  endtask

  vec_t vecs[11];

  initial begin
    rd_rst = 1'b1; fifo_empty = 1'b1; rd_data = '0; out_ready = 1'b0; got = 0;

    //          rst   fe    data   rdy   rd_en valid data   level
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd1};
    vecs[3]  = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2};
    vecs[4]  = '{1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd2};
    vecs[5]  = '{1'b0, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 8'h5A, 2'd1};
    vecs[6]  = '{1'b0, 1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 8'h77, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 8'h77, 2'd1};
    vecs[8]  = '{1'b0, 1'b1, 8'h88, 1'b1, 1'b0, 1'b0, 8'h77, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0, 8'h77, 2'd0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3, 2'd1};

    for (int i = 0; i < 11; i++) begin
      @(negedge rd_clk);
      rd_rst = vecs[i].rst; fifo_empty = vecs[i].fe;
      rd_data = vecs[i].data; out_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_rd_en", i), rd_en, vecs[i].exp_rd_en);
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_level", i), buf_level, vecs[i].exp_level);
      $display("vec %0d: rd_en=%0b valid=%0b data=%02h level=%0d", i, rd_en, out_valid, out_data, buf_level);
    end

    // Streaming 0x01..0x10 with out_ready held high: one word per cycle after first pop.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      src_q.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    for (int c = 0; c < 17; c++) begin
      cycle(1'b1, 1'b1);
      if (c >= 1) check("stream_level", buf_level, 1);
    end
    check("stream_no_bubbles", got, 16);
    $display("stream: %0d words in 17 cycles", got);

    // Stall then release: A5 must be accepted before 5A.
    do_reset();
    src_q.push_back(8'hA5); src_q.push_back(8'h5A);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1);
    check("stall_level", buf_level, 2);
    check("stall_rd_en", rd_en, 0);
    check("stall_data", out_data, 8'hA5);
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1);
    check("stall_release_count", got, 2);
    $display("stall: released %0d words", got);

    // Random backpressure and random FIFO availability over 1000 words.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      logic [DW-1:0] w;
      w = 8'($urandom);
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    for (int c = 0; c < 20000 && got < 1000; c++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("random_word_count", got, 1000);
    $display("random: %0d words received", got);

    // Async reset during a level-2 stall clears state before any edge.
    do_reset();
    src_q.push_back(8'h3C); src_q.push_back(8'hC3); src_q.push_back(8'h99);
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1);
    check("pre_rst_level", buf_level, 2);
    @(negedge rd_clk);
    #2;
    rd_rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_level", buf_level, 0);
    check("async_rst_rd_en", rd_en, 0);
    check("async_rst_data", out_data, 0);
    $display("async reset: valid=%0b level=%0d", out_valid, buf_level);
    #1;
    rd_rst = 1'b0;

`ifdef FIFO_RD_WCNT_EN
    do_reset();
    check("wcnt_after_reset", wcnt, 0);
    for (int i = 0; i < 17; i++) begin
      src_q.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    for (int c = 0; c < 40 && got < 17; c++) cycle(1'b1, 1'b1);
    #1;
    check("wcnt_wrap", wcnt, 1);
    do_reset();
    #1;
    check("wcnt_reset", wcnt, 0);
    $display("wcnt: checked wrap and reset");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
